core_imem: RTL and testbench
============================

Name: core_imem

Overview:
- Instruction memory responder: the memory-side end of the instruction-fetch interface driven by core_ifu.
- Accepts the fetch PC and returns the addressed instruction word one cycle later, registered.
- A streaming program-load port fills the memory before execution, so testbenches and boot logic share one path.
- Sits beside core_ifu at the top level; instr_fetched feeds the IFU's instruction input directly.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- NOP_INSTR, 32'h0000_0013: word returned whenever no valid instruction is available.

Ports:
- clk  input  1: clock.
- rst  input  1: synchronous active-high reset.
- pc_addr  input  `CPU_PC_SIZE: fetch byte address.
- pc_en  input  1: fetch enable; 0 = hold output (stall).
- instr_fetched  output  `CPU_INSTR_SIZE: registered instruction.
- instr_valid  output  1: instr_fetched holds real memory data.
- fetch_fault  output  1: address fault flag; exists only with the optional feature, otherwise tied 0.
- ld_start  input  1: pulse; begin (re)load.
- ld_valid  input  1: load beat valid.
- ld_ready  output  1: load beat accepted when ld_valid and ld_ready are both 1.
- ld_data  input  `CPU_INSTR_SIZE: load word.
- ld_last  input  1: marks final beat.
- ld_err  output  1: sticky overflow flag.
- busy  output  1: high in LOAD state.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state is sampled on the rising clk edge.
- Reset values:
  - state = IDLE, wr_ptr = 0.
  - instr_fetched = NOP_INSTR; instr_valid, fetch_fault, ld_ready, ld_err, busy = 0.
  - Memory array is not reset.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: ld_start -> LOAD. All other inputs are ignored.
  - LOAD: busy = 1, ld_ready = 1.
    - Each handshake writes mem[wr_ptr] = ld_data, then wr_ptr increments.
    - A handshake with ld_last = 1 -> RUN on the next edge.
    - ld_start while in LOAD restarts the load: wr_ptr = 0, ld_err cleared, state stays LOAD.
  - RUN: ld_ready = 0; load beats are ignored. ld_start -> LOAD.
  - Entering LOAD from any state clears wr_ptr and ld_err.
- Overflow: a beat accepted with wr_ptr = DEPTH-1 writes the word, and wr_ptr saturates at DEPTH-1.
  - Any further beat before ld_last is accepted (ld_ready stays 1), its data is dropped, and ld_err sets.
  - ld_err is sticky until the next LOAD entry or reset.
- Fetch, 1-cycle latency:
  - In RUN with pc_en = 1 at edge N: instr_fetched = mem[word] and instr_valid = 1 after edge N.
  - word = ((pc_addr - BASE_ADDR) >> 2) modulo DEPTH; pc_addr[1:0] is ignored.
  - pc_en = 0: instr_fetched, instr_valid and fetch_fault hold their values.
  - Outside RUN: instr_fetched = NOP_INSTR and instr_valid = 0 on every edge, regardless of pc_en.
- Simultaneous events:
  - ld_start in RUN together with pc_en: ld_start wins; output becomes NOP with instr_valid = 0 on that edge.
  - Reset mid-load: abandons the load; memory keeps partially written words; state = IDLE.
- Read/write collision cannot occur (writes only in LOAD, reads only in RUN).
- A single-port synchronous-read memory is sufficient.

Optional Feature:
- Macro: IMEM_ADDR_CHK_EN.
- Defined: a RUN fetch faults if pc_addr[1:0] != 0, or if (pc_addr - BASE_ADDR) >= DEPTH*4 (unsigned).
  - On a fault: instr_fetched = NOP_INSTR, instr_valid = 0, fetch_fault = 1, all aligned to the same edge.
  - fetch_fault otherwise 0; held on pc_en = 0; reset 0.
- Undefined: no checks; low bits are ignored and the address wraps modulo DEPTH; fetch_fault is constant 0.

Test Plan:
- Reset, then pc_en = 1, pc_addr = 0 for 3 cycles -> instr_fetched = 32'h0000_0013, instr_valid = 0, busy = 0, ld_ready = 0.
- ld_start; 4 beats 32'h00A00093, 32'h00108113, 32'h002081B3, 32'h0000006F with ld_last on beat 4 -> busy = 1 for 4 cycles, then RUN; fetch pc 0,4,8,12 -> same words, each 1 cycle later, instr_valid = 1.
- In RUN, pc_addr = 4 with pc_en = 1, then pc_en = 0 and pc_addr = 8 for 2 cycles -> instr_fetched stays 32'h00108113; pc_en = 1 -> 32'h002081B3 next cycle.
- DEPTH = 4: load 6 beats, ld_last on beat 6 -> words 0-3 written, beats 5-6 dropped, ld_err = 1; a later ld_start clears ld_err.
- In RUN, assert ld_start and pc_en on the same edge -> instr_valid = 0, instr_fetched = NOP, busy = 1 next cycle; reset mid-load -> state IDLE, busy = 0.
- IMEM_ADDR_CHK_EN defined, DEPTH = 1024: pc_addr = 32'h2 -> fetch_fault = 1, NOP, instr_valid = 0; pc_addr = 32'h1000 -> fault; pc_addr = 32'hFFC -> fault = 0, mem[1023] returned.

Source files
------------

// File: rtl/core_imem.sv
// core_imem: instruction memory with a streaming program-load port and a registered one-cycle fetch.
// Defining IMEM_ADDR_CHK_EN adds misalignment and out-of-range fetch faults.
`ifndef CPU_PC_SIZE
`define CPU_PC_SIZE 32
`endif
`ifndef CPU_INSTR_SIZE
`define CPU_INSTR_SIZE 32
`endif

module core_imem #(
  parameter int                         DEPTH     = 1024,
  parameter logic [`CPU_PC_SIZE-1:0]    BASE_ADDR = 32'h0000_0000,
  parameter logic [`CPU_INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`CPU_PC_SIZE-1:0]    pc_addr,
  input  logic                       pc_en,
  output logic [`CPU_INSTR_SIZE-1:0] instr_fetched,
  output logic                       instr_valid,
  output logic                       fetch_fault,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [`CPU_INSTR_SIZE-1:0] ld_data,
  input  logic                       ld_last,
  output logic                       ld_err,
  output logic                       busy
);

  localparam int PW = `CPU_PC_SIZE;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_next;

  logic [`CPU_INSTR_SIZE-1:0] mem [DEPTH];
  logic [`CPU_INSTR_SIZE-1:0] rd_word;
  logic [AW-1:0]              wr_ptr;
  logic                       full;
  logic                       err_q;
  logic                       valid_q;
  logic                       fault_q;
  logic [PW-1:0]              offset;
  logic [AW-1:0]              rd_idx;
  logic                       beat;
  logic                       mem_we;
  logic                       fetch_go;
  logic                       addr_fault;

  assign offset   = pc_addr - BASE_ADDR;
  assign rd_idx   = offset[AW+1:2];
  assign beat     = (state == LOAD) && ld_valid && !ld_start;
  assign mem_we   = beat && !full;
  assign fetch_go = (state == RUN) && pc_en && !ld_start;

`ifdef IMEM_ADDR_CHK_EN
  localparam logic [PW:0] LIMIT = (PW + 1)'(DEPTH) << 2;
  assign addr_fault = (pc_addr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{offset[PW-1:AW+2], offset[1:0]};
  assign addr_fault       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ld_start re-enters LOAD from every state, including LOAD itself.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ld_start) state_next = LOAD;
      LOAD: begin
        if (ld_start)                  state_next = LOAD;
        else if (ld_valid && ld_last)  state_next = RUN;
      end
      RUN:  if (ld_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // full marks that word DEPTH-1 has been written; later beats are dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst || ld_start) begin
      wr_ptr <= '0;
      full   <= 1'b0;
      err_q  <= 1'b0;
    end else if (beat) begin
      if (full)                    err_q  <= 1'b1;
      else if (wr_ptr == LAST_WORD) full   <= 1'b1;
      else                         wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Array and read register carry no reset so they map onto a block RAM.
  always_ff @(posedge clk) begin
    if (mem_we)   mem[wr_ptr] <= ld_data;
    if (fetch_go) rd_word     <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst || state != RUN || ld_start) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (pc_en) begin
      valid_q <= !addr_fault;
      fault_q <= addr_fault;
    end
  end

  assign instr_fetched = valid_q ? rd_word : NOP_INSTR;
  assign instr_valid   = valid_q;
  assign fetch_fault   = fault_q;
  assign ld_ready      = (state == LOAD);
  assign busy          = (state == LOAD);
  assign ld_err        = err_q;

endmodule

// File: tb/tb_core_imem.sv
// Self-checking bench for core_imem: a directed vector table plus hand-written load/fault sequences.
// A DEPTH=4 instance exercises load overflow alongside the default-depth instance.
module tb_core_imem;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WA  = 32'h00A0_0093;
  localparam logic [31:0] WB  = 32'h0010_8113;
  localparam logic [31:0] WC  = 32'h0020_81B3;
  localparam logic [31:0] WD  = 32'h0000_006F;

  typedef struct {
    logic        pc_en;
    logic [31:0] pc;
    logic        st;
    logic        vld;
    logic [31:0] data;
    logic        last;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        pc_en = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] pc_addr = '0, ld_data = '0;
  logic [31:0] instr_fetched;
  logic        instr_valid, fetch_fault, ld_ready, ld_err, busy;

  logic        s_pc_en = 1'b0, s_ld_start = 1'b0, s_ld_valid = 1'b0, s_ld_last = 1'b0;
  logic [31:0] s_pc_addr = '0, s_ld_data = '0;
  logic [31:0] s_instr_fetched;
  logic        s_instr_valid, s_fetch_fault, s_ld_ready, s_ld_err, s_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_imem dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_en(pc_en),
    .instr_fetched(instr_fetched), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .ld_err(ld_err), .busy(busy)
  );

  core_imem #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .pc_addr(s_pc_addr), .pc_en(s_pc_en),
    .instr_fetched(s_instr_fetched), .instr_valid(s_instr_valid), .fetch_fault(s_fetch_fault),
    .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_data(s_ld_data),
    .ld_last(s_ld_last), .ld_err(s_ld_err), .busy(s_busy)
  );

  task automatic checkField(input string tag, input string field, input logic [31:0] act,
                            input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
    end
  endtask

  // which = 0 drives the default-depth instance, 1 the DEPTH=4 instance; returns #1 after the edge.
  task automatic applyStimulus(input bit which, input logic en, input logic [31:0] pc,
                               input logic st, input logic vld, input logic [31:0] data,
                               input logic last);
    if (!which) begin
      pc_en = en; pc_addr = pc; ld_start = st; ld_valid = vld; ld_data = data; ld_last = last;
    end else begin
      s_pc_en = en; s_pc_addr = pc; s_ld_start = st; s_ld_valid = vld; s_ld_data = data;
      s_ld_last = last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input bit which, input string tag, input logic [31:0] e_instr,
                             input logic e_valid, input logic e_busy, input logic e_err,
                             input logic e_fault);
    if (!which) begin
      checkField(tag, "instr", instr_fetched, e_instr);
      checkField(tag, "valid", {31'b0, instr_valid}, {31'b0, e_valid});
      checkField(tag, "busy", {31'b0, busy}, {31'b0, e_busy});
      checkField(tag, "ready", {31'b0, ld_ready}, {31'b0, e_busy});
      checkField(tag, "err", {31'b0, ld_err}, {31'b0, e_err});
      checkField(tag, "fault", {31'b0, fetch_fault}, {31'b0, e_fault});
    end else begin
      checkField(tag, "instr", s_instr_fetched, e_instr);
      checkField(tag, "valid", {31'b0, s_instr_valid}, {31'b0, e_valid});
      checkField(tag, "busy", {31'b0, s_busy}, {31'b0, e_busy});
      checkField(tag, "ready", {31'b0, s_ld_ready}, {31'b0, e_busy});
      checkField(tag, "err", {31'b0, s_ld_err}, {31'b0, e_err});
      checkField(tag, "fault", {31'b0, s_fetch_fault}, {31'b0, e_fault});
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] w4 [6];

    tbl.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, NOP, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b1, WA,    1'b0, NOP, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b1, WB,    1'b0, NOP, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b1, WC,    1'b0, NOP, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b1, WD,    1'b1, NOP, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, WA,  1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0, WB,  1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, WC,  1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 1'b0, WD,  1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0, WB,  1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, WB,  1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, WB,  1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, WC,  1'b1, 1'b0});
    tbl.push_back('{1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, NOP, 1'b0, 1'b1});

    rst = 1'b1;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "reset", NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(1, "reset4", NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(0, tbl[i].pc_en, tbl[i].pc, tbl[i].st, tbl[i].vld, tbl[i].data, tbl[i].last);
      checkOutput(0, $sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_busy,
                  1'b0, 1'b0);
    end

    // Partial load abandoned by reset: words already written must survive.
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
    checkOutput(0, "midload", NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    checkOutput(0, "rst_midload", NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "idle_fetch", NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_3333, 1'b1);
    checkOutput(0, "reload_done", NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "reload_w0", 32'h3333_3333, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "kept_w1", 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "kept_w2", WC, 1'b1, 1'b0, 1'b0, 1'b0);
`ifndef IMEM_ADDR_CHK_EN
    applyStimulus(0, 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "lowbits", 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h100C, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "wrap", WD, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // DEPTH=4 overflow: beats 5 and 6 are dropped and set the sticky error.
    w4[0] = 32'hA000_0000; w4[1] = 32'hA000_0001; w4[2] = 32'hA000_0002;
    w4[3] = 32'hA000_0003; w4[4] = 32'hBAD0_0004; w4[5] = 32'hBAD0_0005;
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput(1, "ovf_start", NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b1, w4[i], (i == 5));
      checkOutput(1, $sformatf("ovf_beat%0d", i), NOP, 1'b0, (i != 5), (i >= 4), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput(1, $sformatf("ovf_rd%0d", i), w4[i], 1'b1, 1'b0, 1'b1, 1'b0);
    end
`ifdef IMEM_ADDR_CHK_EN
    applyStimulus(1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(1, "ovf_range", NOP, 1'b0, 1'b0, 1'b1, 1'b1);
`else
    applyStimulus(1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(1, "ovf_wrap", w4[0], 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput(1, "err_clear", NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_0000, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_0000, 1'b1);
    checkOutput(1, "restart_done", NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(1, "restart_w0", 32'h6666_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(1, "restart_w1", w4[1], 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_ADDR_CHK_EN
    // Fill all 1024 words so the last in-range word can be read back.
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 1024; i++)
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000 | 32'(i), (i == 1023));
    checkOutput(0, "chk_loaded", NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "chk_misalign", NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "chk_hold", NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'hFFC, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "chk_top", 32'hC000_03FF, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "chk_range", NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "chk_w0", 32'hC000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
